pipe_field: RTL

- Playfield stage directly downstream of the pipe generator.
- Holds COLS columns of 16-row pipe patterns and scrolls them left at a fixed tick rate.
- Requests new pipe columns from the generator via gen_en and inserts its 16-bit column output on the right edge.
- Detects bird/pipe collision and counts passed pipes; the display and game-control logic read it.

---
 rtl/pipe_field.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_field.sv
// pipe_field
//   Playfield stage that sits directly after the pipe generator. It holds
//   COLS columns of 16-row pipe patterns and scrolls them one column to the
//   left at a fixed tick rate. Fresh pipe columns are requested from the
//   generator with gen_en and inserted at the right edge. The stage also
//   detects bird/pipe collisions and counts the pipes the bird has passed.
//
//   Optional feature, macro PIPE_FIELD_SPEEDUP_EN:
//     defined   - the scroll divider halves each time score crosses a
//                 multiple of 8, floored at MIN_DIV, and is restored to
//                 SCROLL_DIV on start or rst.
//     undefined - the scroll divider is the constant SCROLL_DIV.
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset
//   start         one-cycle pulse that starts or restarts a game
//   new_pipe      column pattern from the generator (1 = pipe)
//   gen_en        one-cycle request; new_pipe is valid on the next cycle
//   bird_row      current bird row, 0..15
//   col_sel       display read column index
//   col_data      registered contents of column col_sel (0 if out of range)
//   running       high while a game is in progress
//   scroll_pulse  one-cycle pulse after each scroll step
//   collision     sticky collision flag, cleared when a game starts
//   score         pipes passed, saturating at 255
//
// States:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | after reset, field empty, waiting for start
//   ST_RUN   | game running: divider ticking, field scrolling
//   ST_OVER  | collision seen, field frozen, waiting for start

module pipe_field #(
  parameter int COLS         = 16,
  parameter int SCROLL_DIV   = 12500000,
  parameter int PIPE_SPACING = 6,
  parameter int PIPE_W       = 2,
  parameter int BIRD_COL     = 3,
  parameter int MIN_DIV      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] new_pipe,
  output logic        gen_en,
  input  logic [3:0]  bird_row,
  input  logic [3:0]  col_sel,
  output logic [15:0] col_data,
  output logic        running,
  output logic        scroll_pulse,
  output logic        collision,
  output logic [7:0]  score
);

  // Wide enough to hold SCROLL_DIV itself, which the speedup register needs.
  localparam int DIV_W = $clog2(SCROLL_DIV + 1);
  localparam int GAP_W = $clog2(PIPE_SPACING + 1);

  // Elaboration-time guards on the parameter relationships the logic relies on.
  if (SCROLL_DIV < 2) begin : g_chk_div
    $error("pipe_field: SCROLL_DIV must be at least 2");
  end
  if (PIPE_SPACING <= PIPE_W) begin : g_chk_spacing
    $error("pipe_field: PIPE_SPACING must exceed PIPE_W");
  end
  if (BIRD_COL >= COLS - 1) begin : g_chk_bird
    $error("pipe_field: BIRD_COL must be less than COLS-1");
  end
  if (MIN_DIV < 2) begin : g_chk_min_div
    $error("pipe_field: MIN_DIV must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t             state;
  logic [15:0]        field [COLS];
  logic [15:0]        pipe_hold;
  logic [DIV_W-1:0]   div_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  logic [DIV_W-1:0]   div_last;   // div_cnt value of the scroll step
  logic [DIV_W-1:0]   div_gen;    // div_cnt value of the generator request
  logic               hit;
  logic               scroll_step;
  logic               score_pass;
  logic               score_inc;
  logic               game_start;
  logic [15:0]        ins_col;

  assign game_start  = (state != ST_RUN) && start;
  assign hit         = field[BIRD_COL][bird_row];
  assign scroll_step = (div_cnt == div_last);

  // A pipe counts as passed once its last column is at the bird and the
  // column behind it is empty, i.e. on the step that pushes it out.
  assign score_pass = (field[BIRD_COL] != '0) && (field[BIRD_COL+1] == '0);

  // Collision suppresses both the scroll and the score update.
  assign score_inc = (state == ST_RUN) && !hit && scroll_step &&
                     score_pass && (score != 8'hFF);

  // gen_en is a decode of registered state only; the generator's one-cycle
  // latency lands new_pipe exactly on the scroll-step cycle.
  assign gen_en  = (state == ST_RUN) && (div_cnt == div_gen) && (gap_cnt == '0);
  assign running = (state == ST_RUN);

`ifdef PIPE_FIELD_SPEEDUP_EN
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] div_half;

  assign div_half = div_eff >> 1;

  // The divider changes on the same edge that wraps div_cnt to 0, so the
  // new period starts cleanly with the next step.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_eff <= DIV_W'(SCROLL_DIV);
    end else if (game_start) begin
      div_eff <= DIV_W'(SCROLL_DIV);
    end else if (score_inc && (score[2:0] == 3'd7)) begin
      if (div_half >= DIV_W'(MIN_DIV)) begin
        div_eff <= div_half;
      end else if (div_eff > DIV_W'(MIN_DIV)) begin
        div_eff <= DIV_W'(MIN_DIV);
      end
    end
  end

  assign div_last = div_eff - DIV_W'(1);
  assign div_gen  = div_eff - DIV_W'(2);
`else
  assign div_last = DIV_W'(SCROLL_DIV - 1);
  assign div_gen  = DIV_W'(SCROLL_DIV - 2);
`endif

  // Right-edge column: the first column of a pipe comes straight from the
  // generator, the remaining PIPE_W-1 columns repeat it, then empty space.
  always_comb begin
    ins_col = '0;
    if (gap_cnt == '0) begin
      ins_col = new_pipe;
    end else if (gap_cnt < GAP_W'(PIPE_W)) begin
      ins_col = pipe_hold;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      pipe_hold    <= '0;
      div_cnt      <= '0;
      gap_cnt      <= '0;
      scroll_pulse <= 1'b0;
      collision    <= 1'b0;
      score        <= '0;
      for (int i = 0; i < COLS; i++) begin
        field[i] <= '0;
      end
    end else begin
      scroll_pulse <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state     <= ST_RUN;
            pipe_hold <= '0;
            div_cnt   <= '0;
            gap_cnt   <= '0;
            collision <= 1'b0;
            score     <= '0;
            for (int i = 0; i < COLS; i++) begin
              field[i] <= '0;
            end
          end
        end

        ST_RUN: begin
          if (hit) begin
            collision <= 1'b1;
            state     <= ST_OVER;
          end else begin
            div_cnt <= scroll_step ? '0 : div_cnt + DIV_W'(1);
            if (scroll_step) begin
              scroll_pulse <= 1'b1;
              for (int i = 0; i < COLS - 1; i++) begin
                field[i] <= field[i+1];
              end
              field[COLS-1] <= ins_col;
              if (gap_cnt == '0) begin
                pipe_hold <= new_pipe;
              end
              gap_cnt <= (gap_cnt == GAP_W'(PIPE_SPACING - 1)) ? '0
                                                               : gap_cnt + GAP_W'(1);
              if (score_inc) begin
                score <= score + 8'd1;
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // Fixed 16-entry read table so any col_sel value is legal; entries past
  // the last column read as empty.
  logic [15:0] rd_tab [16];

  for (genvar g = 0; g < 16; g++) begin : g_rd
    if (g < COLS) begin : g_col
      assign rd_tab[g] = field[g];
    end else begin : g_pad
      assign rd_tab[g] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_data <= '0;
    end else begin
      col_data <= rd_tab[col_sel];
    end
  end

endmodule
